// File: rtl/hamming_encoder_serializer.sv
// Hamming(7,4) transmit stage: nibble FIFO, encoder with error-injection mask,
// parallel codeword strobe and LSB-first serializer with a frame marker.
module hamming_encoder_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             pts_reset,
  input  logic [3:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       inj_mask,
  output logic [6:0]       cw_out,
  output logic             cw_valid,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             ser_first,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]    GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam bit            NO_GAP   = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t        r_state;
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [6:0]    r_shift;
  logic [2:0]    r_bit_idx;
  logic [3:0]    r_gap_cnt;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_frame_end;
  logic [6:0]    w_tx;

  function automatic logic [6:0] encode(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  assign w_empty  = (r_count == '0);
  // NOTE: in_ready depends only on registered occupancy, never on in_valid, so no comb loop with the source.
  assign in_ready = (r_count != DEPTH_C);
  assign w_push   = in_valid & in_ready;
  assign busy     = (r_state != S_IDLE) | !w_empty;

  // A frame slot opens after bit 6 (no gap) or after the last gap cycle.
  assign w_frame_end = (r_state == S_SHIFT && r_bit_idx == 3'd6 && NO_GAP) ||
                       (r_state == S_GAP && r_gap_cnt == GAP_LAST);
  assign w_pop       = !w_empty && (r_state == S_IDLE || w_frame_end);
  assign w_tx        = encode(r_mem[r_rd_ptr]) ^ inj_mask;

  // NOTE: storage array has no reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge pts_reset) begin
    if (pts_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge pts_reset) begin
    if (pts_reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_gap_cnt   <= '0;
      cw_out      <= '0;
      cw_valid    <= 1'b0;
      ser_out     <= 1'b0;
      ser_frame   <= 1'b0;
      ser_first   <= 1'b0;
      frame_count <= '0;
    end else begin
      cw_valid  <= 1'b0;
      ser_first <= 1'b0;
      if (w_pop) begin
        r_state     <= S_SHIFT;
        r_shift     <= w_tx;
        r_bit_idx   <= '0;
        cw_out      <= w_tx;
        cw_valid    <= 1'b1;
        ser_out     <= w_tx[0];
        ser_frame   <= 1'b1;
        ser_first   <= 1'b1;
        frame_count <= frame_count + 1'b1;
      end else begin
        case (r_state)
          S_SHIFT: begin
            if (r_bit_idx != 3'd6) begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              ser_out   <= r_shift[1];
            end else begin
              ser_out   <= 1'b0;
              ser_frame <= 1'b0;
              r_gap_cnt <= '0;
              r_state   <= NO_GAP ? S_IDLE : S_GAP;
            end
          end
          S_GAP: begin
            if (r_gap_cnt == GAP_LAST) r_state <= S_IDLE;
            else                       r_gap_cnt <= r_gap_cnt + 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/hamming_encoder_serializer.md
Name: hamming_encoder_serializer

Overview:
Upstream transmit stage of the Hamming(7,4) link. It accepts 4-bit data nibbles over a valid/ready handshake and buffers them in a small FIFO. Each nibble is encoded into a 7-bit Hamming codeword, and an optional error-injection mask is applied. The block presents the codeword in parallel with a one-cycle strobe for the decoder's enable input, and also shifts it out serially LSB-first with a frame marker.

Parameters:
FIFO_DEPTH, 4, nibble buffer entries; power of two, 2..16
GAP_CYCLES, 1, idle cycles inserted after each serial frame; 0..15
CNT_W, 16, width of the transmitted-frame counter

Ports:
clk  in  1  clock; all state updates on rising edge
pts_reset  in  1  asynchronous, active-high reset
in_data  in  4  data nibble; bit0 = d0 .. bit3 = d3
in_valid  in  1  in_data valid
in_ready  out  1  FIFO can accept a nibble
inj_mask  in  7  codeword bits to invert; sampled at load
cw_out  out  7  last encoded (and injected) codeword, parallel
cw_valid  out  1  one-cycle pulse when cw_out updates; drives decoder enable
ser_out  out  1  serial codeword bit, LSB (bit0) first
ser_frame  out  1  high while ser_out carries a codeword bit
ser_first  out  1  high during bit0 of each frame
busy  out  1  FSM not in IDLE or FIFO not empty
frame_count  out  CNT_W  frames loaded since reset, wraps

Behaviour:
- Reset (async assert, sync release): FIFO empty, FSM IDLE, cw_out=0, cw_valid=0, ser_out=0, ser_frame=0, ser_first=0, frame_count=0, busy=0, in_ready=1.
- Encoding, with d=in_data:
  - cw[0]=d0^d1^d3, cw[1]=d0^d2^d3, cw[2]=d0, cw[3]=d1^d2^d3, cw[4]=d1, cw[5]=d2, cw[6]=d3.
  - Transmitted word is tx=cw^inj_mask.
- Input handshake:
  - A push occurs on an edge with in_valid & in_ready.
  - in_ready = !full, combinational from FIFO occupancy only.
  - A push while full is impossible; in_valid while !in_ready is ignored and the data is held by the source.
- FIFO:
  - Pointers wrap modulo FIFO_DEPTH; a separate count distinguishes full from empty.
  - A pushed nibble is poppable no earlier than the next edge (no fall-through).
  - Simultaneous push and pop keep the count unchanged.
- FSM states IDLE, SHIFT, GAP:
  - IDLE: if FIFO non-empty at an edge, pop and load.
  - Load: shift register <= tx; cw_out <= tx; cw_valid=1 for exactly that following cycle; ser_out=tx[0], ser_frame=1, ser_first=1; bit index=0; frame_count+1; go to SHIFT.
  - SHIFT: each edge advances the bit index and ser_out=tx[idx], with ser_first=0.
  - Edge leaving bit 6, GAP_CYCLES>0: go to GAP, ser_frame=0, ser_out=0.
  - Edge leaving bit 6, GAP_CYCLES=0: if FIFO non-empty, load directly (back-to-back frames, 7 cycles each); else go to IDLE.
  - GAP: counts GAP_CYCLES cycles with ser_frame=0. On the edge ending the last gap cycle, load if non-empty, else go to IDLE.
- Latency: nibble pushed at edge N with the FIFO empty and FSM IDLE gives cw_valid/ser_first high in the cycle after edge N+1.
- Frame period: 7+GAP_CYCLES cycles under continuous input.
- inj_mask is sampled only at load; changes mid-frame do not affect the frame in flight.
- cw_out holds its value between loads. cw_valid never asserts on consecutive cycles unless GAP_CYCLES=0 is impossible (period ≥7).
- frame_count wraps from 2^CNT_W-1 to 0.
- pts_reset mid-frame: frame aborted immediately, all outputs return to reset values, FIFO contents discarded.
- busy = (state!=IDLE) | !empty.

Test Plan:
- Encoding sweep: push 0x0, 0x1, 0xB, 0xF with mask 0 -> cw_out = 7'h00, 7'h07, 7'h55, 7'h7F; each with one cw_valid pulse; ser_out bits LSB-first match cw_out.
- Injection: push 0xB with inj_mask=7'h10 -> cw_out=7'h45. Mask changed to 0 mid-frame -> serial bits still follow 7'h45.
- Backpressure: FIFO_DEPTH=4, hold in_valid with 6 nibbles while the first frame shifts -> in_ready drops when 4 are buffered; no nibble lost or duplicated; output order equals input order.
- Framing: GAP_CYCLES=0 with continuous input -> ser_frame stays high, ser_first every 7 cycles. GAP_CYCLES=2 -> ser_frame low for exactly 2 cycles between frames.
- Reset mid-frame: assert pts_reset at bit 3 with 2 nibbles queued -> outputs immediately at reset values, in_ready=1, busy=0, frame_count=0; no further frames after release without new pushes.
- Counter wrap: CNT_W=4, send 17 frames -> frame_count reads 1.
